// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: PC feedback, branch redirect, memory read port and decode handshake.
// The master modport is the fetch stage; the slave modport is its surroundings.
interface instruction_fetch_if #(
   parameter int unsigned OPERAND_WIDTH = 11,
   parameter int unsigned INSTR_WIDTH   = 16
);
   logic [OPERAND_WIDTH-1:0] if_pc;
   logic [OPERAND_WIDTH-1:0] if_pc_next;
   logic                     if_pc_wr;
   logic                     if_branch;
   logic [OPERAND_WIDTH-1:0] if_branch_addr;
   logic                     if_mem_req;
   logic [OPERAND_WIDTH-1:0] if_mem_addr;
   logic                     if_mem_ack;
   logic [INSTR_WIDTH-1:0]   if_mem_data;
   logic [INSTR_WIDTH-1:0]   if_instr;
   logic [OPERAND_WIDTH-1:0] if_instr_pc;
   logic                     if_valid;
   logic                     if_ready;

   modport master (
      input  if_pc, if_branch, if_branch_addr, if_mem_ack, if_mem_data, if_ready,
      output if_pc_next, if_pc_wr, if_mem_req, if_mem_addr, if_instr, if_instr_pc, if_valid
   );

   modport slave (
      output if_pc, if_branch, if_branch_addr, if_mem_ack, if_mem_data, if_ready,
      input  if_pc_next, if_pc_wr, if_mem_req, if_mem_addr, if_instr, if_instr_pc, if_valid
   );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: reads instruction memory at the current PC, hands the word to decode,
// and steers program_counter for sequential increment and branch redirects.
module instruction_fetch #(
   parameter int unsigned OPERAND_WIDTH = 11,
   parameter int unsigned INSTR_WIDTH   = 16
) (
   input  logic                clock,
   input  logic                if_reset_n,
   instruction_fetch_if.master bus
);
   localparam int unsigned OW = OPERAND_WIDTH;
   localparam int unsigned IW = INSTR_WIDTH;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [OW-1:0] fetch_addr;
   logic [OW-1:0] redirect;
   logic [IW-1:0] instr_q;
   logic [OW-1:0] instr_pc_q;
   logic          valid_q;

   // State register
   always_ff @(posedge clock) begin
      if (!if_reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  state_nxt = REQ;
         REQ: begin
            if (bus.if_mem_ack && !bus.if_branch) begin
               state_nxt = HOLD;
            end else if (!bus.if_mem_ack && bus.if_branch) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (bus.if_mem_ack) begin
               state_nxt = REQ;
            end
         end
         HOLD: begin
            if (bus.if_branch || bus.if_ready) begin
               state_nxt = REQ;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Memory port and PC steering; a branch always wins over the sequential increment
   always_comb begin
      bus.if_mem_req  = 1'b0;
      bus.if_mem_addr = fetch_addr;
      bus.if_pc_wr    = 1'b0;
      bus.if_pc_next  = fetch_addr;
      if (if_reset_n) begin
         bus.if_mem_req = (state == REQ) || (state == DRAIN);
         if (bus.if_branch) begin
            bus.if_pc_wr   = 1'b1;
            bus.if_pc_next = bus.if_branch_addr;
         end else if ((state == REQ) && bus.if_mem_ack) begin
            bus.if_pc_wr   = 1'b1;
            bus.if_pc_next = OW'(fetch_addr + OW'(1));
         end
      end
   end

   // Fetch address, pending redirect and the decode-facing instruction register
   always_ff @(posedge clock) begin
      if (!if_reset_n) begin
         fetch_addr <= '0;
         redirect   <= '0;
         instr_q    <= '0;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: fetch_addr <= bus.if_branch ? bus.if_branch_addr : bus.if_pc;
            REQ: begin
               if (bus.if_mem_ack) begin
                  if (bus.if_branch) begin
                     fetch_addr <= bus.if_branch_addr;
                  end else begin
                     instr_q    <= bus.if_mem_data;
                     instr_pc_q <= fetch_addr;
                     valid_q    <= 1'b1;
                  end
               end else if (bus.if_branch) begin
                  redirect <= bus.if_branch_addr;
               end
            end
            // Open read must complete before the redirect target is fetched
            DRAIN: begin
               if (bus.if_mem_ack) begin
                  fetch_addr <= bus.if_branch ? bus.if_branch_addr : redirect;
               end else if (bus.if_branch) begin
                  redirect <= bus.if_branch_addr;
               end
            end
            HOLD: begin
               if (bus.if_branch) begin
                  valid_q    <= 1'b0;
                  fetch_addr <= bus.if_branch_addr;
               end else if (bus.if_ready) begin
                  valid_q    <= 1'b0;
                  fetch_addr <= bus.if_pc;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.if_instr    = instr_q;
   assign bus.if_instr_pc = instr_pc_q;
   assign bus.if_valid    = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small program_counter model in the loop.
module tb_instruction_fetch;
   localparam int unsigned OW = 11;
   localparam int unsigned IW = 16;

   logic clock = 1'b0;
   logic if_reset_n;
   int   errors = 0;
   int   checks = 0;

   logic          pc_load;
   logic [OW-1:0] pc_load_val;
   logic [OW-1:0] pc_q;

   instruction_fetch_if #(.OPERAND_WIDTH(OW), .INSTR_WIDTH(IW)) bus ();

   instruction_fetch #(.OPERAND_WIDTH(OW), .INSTR_WIDTH(IW)) dut (
      .clock      (clock),
      .if_reset_n (if_reset_n),
      .bus        (bus.master)
   );

   always #5 clock = ~clock;

   // program_counter stand-in: bench preload, otherwise follows pc_wr
   always @(posedge clock) begin
      if (pc_load) begin
         pc_q <= pc_load_val;
      end else if (bus.if_pc_wr) begin
         pc_q <= bus.if_pc_next;
      end
   end
   assign bus.if_pc = pc_q;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reset with PC preloaded, then release; returns with the first read open at addr
   task automatic reset_to(input logic [OW-1:0] addr);
      if_reset_n  = 1'b0;
      pc_load     = 1'b1;
      pc_load_val = addr;
      tick();
      pc_load    = 1'b0;
      if_reset_n = 1'b1;
      tick();
   endtask

   initial begin
      if_reset_n         = 1'b0;
      pc_load            = 1'b1;
      pc_load_val        = 11'h005;
      bus.if_branch      = 1'b1;
      bus.if_branch_addr = 11'h123;
      bus.if_mem_ack     = 1'b0;
      bus.if_mem_data    = 16'h0000;
      bus.if_ready       = 1'b0;

      // 1: reset held with branch asserted
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_valid", 32'(bus.if_valid), 32'd0);
         check("rst_req", 32'(bus.if_mem_req), 32'd0);
         check("rst_pc_wr", 32'(bus.if_pc_wr), 32'd0);
      end
      bus.if_branch = 1'b0;
      pc_load       = 1'b0;
      if_reset_n    = 1'b1;
      #1;
      check("idle_req", 32'(bus.if_mem_req), 32'd0);
      tick();
      check("first_req", 32'(bus.if_mem_req), 32'd1);
      check("first_addr", 32'(bus.if_mem_addr), 32'h005);

      // 2: two-cycle memory latency then A5C3
      reset_to(11'h010);
      check("t2_addr", 32'(bus.if_mem_addr), 32'h010);
      check("t2_no_wr", 32'(bus.if_pc_wr), 32'd0);
      tick();
      check("t2_addr_held", 32'(bus.if_mem_addr), 32'h010);
      tick();
      bus.if_mem_ack  = 1'b1;
      bus.if_mem_data = 16'hA5C3;
      #1;
      check("t2_pc_wr", 32'(bus.if_pc_wr), 32'd1);
      check("t2_pc_next", 32'(bus.if_pc_next), 32'h011);
      tick();
      bus.if_mem_ack = 1'b0;
      #1;
      check("t2_valid", 32'(bus.if_valid), 32'd1);
      check("t2_instr", 32'(bus.if_instr), 32'hA5C3);
      check("t2_instr_pc", 32'(bus.if_instr_pc), 32'h010);
      check("t2_pc_wr_off", 32'(bus.if_pc_wr), 32'd0);

      // 3: decode stalls for five cycles
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t3_valid", 32'(bus.if_valid), 32'd1);
         check("t3_instr", 32'(bus.if_instr), 32'hA5C3);
         check("t3_req", 32'(bus.if_mem_req), 32'd0);
      end
      bus.if_ready = 1'b1;
      tick();
      bus.if_ready = 1'b0;
      check("t3_next_addr", 32'(bus.if_mem_addr), 32'h011);
      check("t3_next_req", 32'(bus.if_mem_req), 32'd1);
      check("t3_valid_off", 32'(bus.if_valid), 32'd0);

      // 4: PC wraps from 7FF
      reset_to(11'h7FF);
      check("t4_addr", 32'(bus.if_mem_addr), 32'h7FF);
      bus.if_mem_ack  = 1'b1;
      bus.if_mem_data = 16'h1234;
      #1;
      check("t4_pc_wr", 32'(bus.if_pc_wr), 32'd1);
      check("t4_wrap", 32'(bus.if_pc_next), 32'h000);
      tick();
      bus.if_mem_ack = 1'b0;
      check("t4_instr", 32'(bus.if_instr), 32'h1234);
      check("t4_instr_pc", 32'(bus.if_instr_pc), 32'h7FF);
      bus.if_ready = 1'b1;
      tick();
      bus.if_ready = 1'b0;
      check("t4_next_addr", 32'(bus.if_mem_addr), 32'h000);

      // 5: branch while a read is open at 020
      reset_to(11'h020);
      tick();
      bus.if_branch      = 1'b1;
      bus.if_branch_addr = 11'h200;
      #1;
      check("t5_br_wr", 32'(bus.if_pc_wr), 32'd1);
      check("t5_br_next", 32'(bus.if_pc_next), 32'h200);
      tick();
      bus.if_branch = 1'b0;
      #1;
      check("t5_drain_addr", 32'(bus.if_mem_addr), 32'h020);
      check("t5_drain_req", 32'(bus.if_mem_req), 32'd1);
      check("t5_drain_wr", 32'(bus.if_pc_wr), 32'd0);
      tick();
      check("t5_drain_addr2", 32'(bus.if_mem_addr), 32'h020);
      tick();
      bus.if_mem_ack  = 1'b1;
      bus.if_mem_data = 16'hDEAD;
      #1;
      check("t5_disc_wr", 32'(bus.if_pc_wr), 32'd0);
      tick();
      bus.if_mem_ack = 1'b0;
      #1;
      check("t5_no_valid", 32'(bus.if_valid), 32'd0);
      check("t5_new_addr", 32'(bus.if_mem_addr), 32'h200);

      // ack and branch together: data dropped, refetch at target
      bus.if_mem_ack     = 1'b1;
      bus.if_branch      = 1'b1;
      bus.if_branch_addr = 11'h300;
      #1;
      check("ab_pc_next", 32'(bus.if_pc_next), 32'h300);
      tick();
      bus.if_branch = 1'b0;
      bus.if_mem_data = 16'h0BEE;
      #1;
      check("ab_no_valid", 32'(bus.if_valid), 32'd0);
      check("ab_addr", 32'(bus.if_mem_addr), 32'h300);
      tick();
      bus.if_mem_ack = 1'b0;
      check("ab_instr_pc", 32'(bus.if_instr_pc), 32'h300);

      // branch in HOLD flushes even with ready high
      bus.if_branch      = 1'b1;
      bus.if_branch_addr = 11'h050;
      bus.if_ready       = 1'b1;
      #1;
      check("hb_pc_next", 32'(bus.if_pc_next), 32'h050);
      tick();
      bus.if_branch = 1'b0;
      bus.if_ready  = 1'b0;
      #1;
      check("hb_valid", 32'(bus.if_valid), 32'd0);
      check("hb_addr", 32'(bus.if_mem_addr), 32'h050);

      // 6: reset in HOLD, then in an open REQ
      bus.if_mem_ack  = 1'b1;
      bus.if_mem_data = 16'h7777;
      tick();
      bus.if_mem_ack = 1'b0;
      check("t6_hold_valid", 32'(bus.if_valid), 32'd1);
      if_reset_n = 1'b0;
      tick();
      check("t6_valid", 32'(bus.if_valid), 32'd0);
      check("t6_req", 32'(bus.if_mem_req), 32'd0);
      if_reset_n = 1'b1;
      #1;
      check("t6_idle_req", 32'(bus.if_mem_req), 32'd0);
      tick();
      check("t6_req_addr", 32'(bus.if_mem_addr), 32'h051);
      if_reset_n = 1'b0;
      #1;
      check("t6_req_drop", 32'(bus.if_mem_req), 32'd0);
      tick();
      if_reset_n = 1'b1;
      #1;
      check("t6_idle2_req", 32'(bus.if_mem_req), 32'd0);
      check("t6_idle2_valid", 32'(bus.if_valid), 32'd0);
      tick();
      check("t6_refetch", 32'(bus.if_mem_addr), 32'h051);
      check("t6_refetch_req", 32'(bus.if_mem_req), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
